// File: rtl/sobol_pkg.sv
// Shared Sobol stream definitions: word layout and estimator FSM encoding.
// The generator and its consumers slice x and y from the same positions.
package sobol_pkg;

  localparam int SOBOL_W = 32;
  localparam int DIM_W   = 16;
  localparam int X_LSB   = 16;
  localparam int Y_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sobol_point_in_circle.sv
// Three-stage unit-circle test: register, square, sum/compare.
// A point is a hit when x^2 + y^2 < 2^32 (Q0.16 operands).
module sobol_point_in_circle
  import sobol_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [DIM_W-1:0] i_x,
  input  logic [DIM_W-1:0] i_y,
  output logic             o_valid,
  output logic             o_hit
);

  logic             r_v1, r_v2, r_v3;
  logic [DIM_W-1:0] r_x, r_y;
  logic [31:0]      r_sq_x, r_sq_y;
  logic             r_hit;
  logic [31:0]      w_x32, w_y32;
  logic [32:0]      w_sum;

  assign w_x32 = {16'b0, r_x};
  assign w_y32 = {16'b0, r_y};
  assign w_sum = {1'b0, r_sq_x} + {1'b0, r_sq_y};

  // Only the valid bits need reset; data is qualified by them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge i_clk) begin
    r_x    <= i_x;
    r_y    <= i_y;
    r_sq_x <= w_x32 * w_x32;
    r_sq_y <= w_y32 * w_y32;
    r_hit  <= ~w_sum[32];
  end

  assign o_valid = r_v3;
  assign o_hit   = r_hit;

endmodule

// File: rtl/sobol_mc_pi_estimator.sv
// Counts Sobol points inside the unit quarter circle over 2^N_LOG2 samples.
//   state | meaning
//   IDLE  | waiting for start; hit_count holds last result
//   RUN   | accepting samples until 2^N_LOG2 have been taken
//   DRAIN | letting the last samples clear the circle pipeline
//   DONE  | one-cycle done pulse, hit_count final
module sobol_mc_pi_estimator
  import sobol_pkg::*;
#(
  parameter int N_LOG2     = 10,
  parameter int PIPE_DEPTH = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_sample_valid,
  input  logic [SOBOL_W-1:0] i_sample,
  output logic               o_busy,
  output logic               o_done,
  output logic [N_LOG2:0]    o_hit_count
);

  // Loaded with PIPE_DEPTH-1 and counted down to zero inclusive, so the
  // final in-flight sample lands in the accumulator before DONE.
  localparam logic [1:0] DRAIN_LOAD = 2'(PIPE_DEPTH - 1);

  state_e              r_state, w_next;
  logic [N_LOG2-1:0]   r_sample_cnt;
  logic [1:0]          r_drain_cnt;
  logic [N_LOG2:0]     r_acc;
  logic                w_accept, w_last, w_drain_tc;
  logic                w_pipe_valid, w_pipe_hit;

  assign w_accept   = (r_state == ST_RUN) && i_sample_valid;
  assign w_last     = w_accept && (r_sample_cnt == '1);
  assign w_drain_tc = (r_drain_cnt == 2'd0);

  sobol_point_in_circle u_pic (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_accept),
    .i_x     (i_sample[X_LSB +: DIM_W]),
    .i_y     (i_sample[Y_LSB +: DIM_W]),
    .o_valid (w_pipe_valid),
    .o_hit   (w_pipe_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start)    w_next = ST_RUN;
      ST_RUN:   if (w_last)     w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_tc) w_next = ST_DONE;
      ST_DONE:                  w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      ST_RUN, ST_DRAIN: o_busy = 1'b1;
      ST_DONE:          o_done = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample_cnt <= '0;
      r_drain_cnt  <= '0;
      r_acc        <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_sample_cnt <= '0;
        r_acc        <= '0;
      end else begin
        if (w_accept)                 r_sample_cnt <= r_sample_cnt + N_LOG2'(1);
        if (w_pipe_valid && w_pipe_hit) r_acc      <= r_acc + (N_LOG2+1)'(1);
      end
      if (w_last)
        r_drain_cnt <= DRAIN_LOAD;
      else if ((r_state == ST_DRAIN) && !w_drain_tc)
        r_drain_cnt <= r_drain_cnt - 2'd1;
    end
  end

  assign o_hit_count = r_acc;

endmodule

// File: tb/tb_sobol_mc_pi_estimator.sv
// Directed bench: small-run cases on an N_LOG2=2 instance, plus a full
// 1024-point Sobol run on an N_LOG2=10 instance against a golden count.
module tb_sobol_mc_pi_estimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sv;
  logic [31:0] smp;
  logic        busy, done;
  logic [2:0]  hit;
  logic        b_start, b_sv;
  logic [31:0] b_smp;
  logic        b_busy, b_done;
  logic [10:0] b_hit;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sobol_mc_pi_estimator #(.N_LOG2(2), .PIPE_DEPTH(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sample_valid(sv),
    .i_sample(smp), .o_busy(busy), .o_done(done), .o_hit_count(hit)
  );

  sobol_mc_pi_estimator #(.N_LOG2(10), .PIPE_DEPTH(3)) dut10 (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_sample_valid(b_sv),
    .i_sample(b_smp), .o_busy(b_busy), .o_done(b_done), .o_hit_count(b_hit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1; sv = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_hit_cleared"}, 32'(hit), 32'd0);
  endtask

  task automatic feed(input logic v, input logic [31:0] w, input logic st);
    sv = v; smp = w; start = st;
    @(negedge clk);
  endtask

  // Called at the first negedge after the last accepted sample.
  task automatic finish_run(input string tag, input int exp_hits, input logic junk);
    int          first = -1;
    int          nd    = 0;
    logic [31:0] h_at  = 32'hFFFF_FFFF;
    logic        bz    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        if (first < 0) first = i;
        nd++;
        h_at = 32'(hit);
      end
      if (i == 4) bz = busy;
      if (junk) begin
        start = (i <= 3); sv = 1'b1; smp = 32'h0;
      end else begin
        start = 1'b0; sv = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; sv = 1'b0;
    chk({tag, "_done_latency"}, 32'(first), 32'd3);
    chk({tag, "_done_count"}, 32'(nd), 32'd1);
    chk({tag, "_hits"}, h_at, 32'(exp_hits));
    chk({tag, "_busy_after"}, 32'(bz), 32'd0);
  endtask

  logic [15:0] v0 [16];
  logic [15:0] v1 [16];

  initial begin
    rst = 1'b1; start = 1'b0; sv = 1'b0; smp = '0;
    b_start = 1'b0; b_sv = 1'b0; b_smp = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hit10", 32'(b_hit), 32'd0);

    // 1: four origin points, all hits
    do_start("t1");
    for (int i = 0; i < 4; i++) feed(1'b1, 32'h0000_0000, 1'b0);
    finish_run("t1", 4, 1'b0);

    // 2: corner points miss; x=0,y=max hits
    do_start("t2a");
    for (int i = 0; i < 4; i++) feed(1'b1, 32'hFFFF_FFFF, 1'b0);
    finish_run("t2a", 0, 1'b0);
    feed(1'b0, 32'h0, 1'b0);
    do_start("t2b");
    for (int i = 0; i < 4; i++) feed(1'b1, 32'h0000_FFFF, 1'b0);
    finish_run("t2b", 4, 1'b0);

    // 3: just inside / just outside the circle
    do_start("t3");
    feed(1'b1, 32'hB504_B504, 1'b0);
    feed(1'b1, 32'hB505_B505, 1'b0);
    feed(1'b1, 32'hB504_B504, 1'b0);
    feed(1'b1, 32'hB505_B505, 1'b0);
    finish_run("t3", 2, 1'b0);

    // 4: gaps, stray starts, samples in DRAIN/DONE/IDLE
    do_start("t4");
    feed(1'b1, 32'h0000_0000, 1'b0);
    feed(1'b0, 32'h0000_0000, 1'b1);
    feed(1'b0, 32'h0000_0000, 1'b1);
    feed(1'b1, 32'hFFFF_FFFF, 1'b0);
    feed(1'b1, 32'hFFFF_FFFF, 1'b1);
    feed(1'b0, 32'h0000_0000, 1'b1);
    feed(1'b1, 32'hFFFF_FFFF, 1'b0);
    finish_run("t4", 1, 1'b1);
    chk("t4_hit_hold", 32'(hit), 32'd1);
    chk("t4_idle_after", 32'(busy), 32'd0);

    // 5: reset mid-run
    do_start("t5");
    feed(1'b1, 32'h0, 1'b0);
    feed(1'b1, 32'h0, 1'b0);
    sv = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_hit_rst", 32'(hit), 32'd0);
    begin
      int nd = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("t5_no_done", 32'(nd), 32'd0);
      chk("t5_hit_quiet", 32'(hit), 32'd0);
    end
    do_start("t5b");
    for (int i = 0; i < 4; i++) feed(1'b1, 32'h0, 1'b0);
    finish_run("t5b", 4, 1'b0);

    // 6: 1024 Sobol points against a golden count
    for (int k = 0; k < 16; k++) v0[k] = 16'h8000 >> k;
    v1[0] = 16'h8000;
    for (int k = 1; k < 16; k++) v1[k] = v1[k-1] ^ (v1[k-1] >> 1);
    begin
      logic [15:0] x, y;
      logic [31:0] m;
      longint      s;
      int          golden = 0;
      int          cyc    = 0;
      int          c;
      x = '0; y = '0;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int n = 0; n < 1024; n++) begin
        if (n > 0) begin
          m = 32'(n - 1);
          c = 0;
          while (m[c]) c++;
          x = x ^ v0[c];
          y = y ^ v1[c];
        end
        s = longint'(x) * longint'(x) + longint'(y) * longint'(y);
        if (s < 64'h1_0000_0000) golden++;
        b_sv = 1'b1; b_smp = {x, y};
        @(negedge clk);
        cyc++;
      end
      b_sv = 1'b0;
      while (!b_done && cyc < 1100) begin
        @(negedge clk);
        cyc++;
      end
      chk("t6_done_seen", 32'(b_done), 32'd1);
      chk("t6_done_cycles", 32'(cyc), 32'd1027);
      chk("t6_hits", 32'(b_hit), 32'(golden));
      @(negedge clk);
      chk("t6_idle", 32'(b_busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
